// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID consumer.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN  = 1'b0;
  localparam fetch_state_t HALT = 1'b1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: 64'd0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect / +4 / hold next-PC selection and fetch legality check.
module fetch_pc_reg #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        hold,
  input  logic [63:0] target,
  output logic [63:0] pc,
  output logic        legal
);

  // Highest legal word address is MEM_SIZE-4; comparing against MEM_SIZE-3
  // avoids forming pc+3, which could wrap for very large PCs.
  localparam logic [63:0] LIMIT = 64'(MEM_SIZE - 3);

  assign legal = (pc[1:0] == 2'b00) && (pc < LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pc <= RESET_PC;
    else if (load)  pc <= target;
    else if (!hold) pc <= pc + 64'd4;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures ROM data into IF/ID, runs the RUN/HALT FSM.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] instr_addr,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault
);

  fetch_state_t state;
  if_id_t       if_id;
  logic [63:0]  pc;
  logic         pc_legal;
  logic         run;
  logic         pc_load;
  logic         pc_hold;

  assign run     = (state == RUN);
  assign pc_load = run && redirect_valid;
  assign pc_hold = !run || !pc_legal || stall;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC),
    .MEM_SIZE(MEM_SIZE)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .hold  (pc_hold),
    .target(redirect_target),
    .pc    (pc),
    .legal (pc_legal)
  );

  // Redirect wins over everything; an illegal PC halts before stall/flush are considered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fault <= 1'b0;
      if_id <= IF_ID_BUBBLE;
    end else if (run) begin
      if (redirect_valid) begin
        if_id <= IF_ID_BUBBLE;
      end else if (!pc_legal) begin
        state <= HALT;
        fault <= 1'b1;
        if_id <= IF_ID_BUBBLE;
      end else if (stall) begin
        if_id <= if_id;
      end else if (flush) begin
        if_id <= IF_ID_BUBBLE;
      end else begin
        if_id <= '{pc: pc, instr: instr_in, valid: 1'b1};
      end
    end else begin
      if_id <= IF_ID_BUBBLE;
    end
  end

  assign instr_addr  = pc;
  assign if_id_pc    = if_id.pc;
  assign if_id_instr = if_id.instr;
  assign if_id_valid = if_id.valid;
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a behavioural ROM {16'hA5A5, addr[15:0]}.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] instr_addr;
  logic [31:0] instr_in;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(64'd0), .MEM_SIZE(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_addr     (instr_addr),
    .instr_in       (instr_in),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  always_comb begin
    instr_in = 32'hDEADBEEF;
    if (instr_addr < 64'd1024) instr_in = {16'hA5A5, instr_addr[15:0]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                            input logic valid);
    check({tag, "_pc"}, if_id_pc, pc);
    check({tag, "_instr"}, {32'd0, if_id_instr}, {32'd0, instr});
    check({tag, "_valid"}, {63'd0, if_id_valid}, {63'd0, valid});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, instr_addr, 64'd0);
    check_ifid(tag, 64'd0, NOP, 1'b0);
    check({tag, "_halted"}, {63'd0, halted}, 64'd0);
    check({tag, "_fault"}, {63'd0, fault}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 64'd0;
    #22;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Free run: first edge after reset produces a valid IF/ID entry.
    step();
    check_ifid("run0", 64'd0, 32'hA5A5_0000, 1'b1);
    check("run0_addr", instr_addr, 64'd4);
    step();
    check_ifid("run1", 64'd4, 32'hA5A5_0004, 1'b1);
    check("run1_addr", instr_addr, 64'd8);

    // Stall two cycles at PC=8.
    stall = 1'b1;
    step();
    check_ifid("stall0", 64'd4, 32'hA5A5_0004, 1'b1);
    check("stall0_addr", instr_addr, 64'd8);
    step();
    check_ifid("stall1", 64'd4, 32'hA5A5_0004, 1'b1);
    check("stall1_addr", instr_addr, 64'd8);
    stall = 1'b0;
    step();
    check_ifid("unstall", 64'd8, 32'hA5A5_0008, 1'b1);
    check("unstall_addr", instr_addr, 64'd12);

    // Flush at PC=12.
    flush = 1'b1;
    step();
    check("flush_instr", {32'd0, if_id_instr}, {32'd0, NOP});
    check("flush_valid", {63'd0, if_id_valid}, 64'd0);
    check("flush_addr", instr_addr, 64'd16);
    flush = 1'b0;
    step();
    check_ifid("postflush", 64'd16, 32'hA5A5_0010, 1'b1);
    check("postflush_addr", instr_addr, 64'd20);

    // Redirect overrides a simultaneous stall.
    redirect_valid = 1'b1;
    redirect_target = 64'h40;
    stall = 1'b1;
    step();
    check("redir_addr", instr_addr, 64'h40);
    check("redir_valid", {63'd0, if_id_valid}, 64'd0);
    redirect_valid = 1'b0;
    stall = 1'b0;
    step();
    check_ifid("postredir", 64'h40, 32'hA5A5_0040, 1'b1);
    check("postredir_addr", instr_addr, 64'h44);

    // Stall and flush together: flush ignored.
    stall = 1'b1;
    flush = 1'b1;
    step();
    check_ifid("stallflush", 64'h40, 32'hA5A5_0040, 1'b1);
    check("stallflush_addr", instr_addr, 64'h44);
    stall = 1'b0;
    flush = 1'b0;

    // Misaligned redirect target halts one cycle later.
    redirect_valid = 1'b1;
    redirect_target = 64'h42;
    step();
    check("misal_addr", instr_addr, 64'h42);
    check("misal_halted_early", {63'd0, halted}, 64'd0);
    redirect_valid = 1'b0;
    step();
    check("misal_halted", {63'd0, halted}, 64'd1);
    check("misal_fault", {63'd0, fault}, 64'd1);
    check("misal_addr_frozen", instr_addr, 64'h42);
    check("misal_valid", {63'd0, if_id_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_target = 64'd0;
    step();
    check("halt_ignores_redir", instr_addr, 64'h42);
    check("halt_sticky", {63'd0, halted}, 64'd1);
    redirect_valid = 1'b0;
    step();
    check("halt_hold_addr", instr_addr, 64'h42);

    reset = 1'b1;
    #1;
    check_reset_outputs("reset2");
    reset = 1'b0;

    // Sequential falloff at the top of the 1024-byte ROM.
    redirect_valid = 1'b1;
    redirect_target = 64'd1016;
    step();
    check("top_addr", instr_addr, 64'd1016);
    redirect_valid = 1'b0;
    step();
    check_ifid("top0", 64'd1016, 32'hA5A5_03F8, 1'b1);
    step();
    check_ifid("top1", 64'd1020, 32'hA5A5_03FC, 1'b1);
    check("top1_addr", instr_addr, 64'd1024);
    check("top1_halted", {63'd0, halted}, 64'd0);
    step();
    check("fall_halted", {63'd0, halted}, 64'd1);
    check("fall_fault", {63'd0, fault}, 64'd1);
    check("fall_addr", instr_addr, 64'd1024);
    check("fall_valid", {63'd0, if_id_valid}, 64'd0);

    reset = 1'b1;
    #1;
    check_reset_outputs("reset3");
    reset = 1'b0;

    // Mid-run asynchronous reset at PC=0x20.
    for (int i = 0; i < 8; i++) step();
    check("midrun_addr", instr_addr, 64'h20);
    check_ifid("midrun", 64'h1C, 32'hA5A5_001C, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    step();
    check_ifid("after_midreset", 64'd0, 32'hA5A5_0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined ARM CPU.
- Owns the program counter and drives the byte address into the combinational instruction ROM.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall, flush and branch redirect from downstream hazard/branch logic, and halts cleanly on an illegal fetch address.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- MEM_SIZE, 1024, instruction ROM size in bytes; must be a power of two, >4.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- instr_addr  out  64  byte address to instruction ROM; equals current PC (combinational from PC register).
- instr_in  in  32  instruction word returned by ROM for instr_addr, same cycle.
- stall  in  1  hold PC and IF/ID contents (load-use hazard).
- flush  in  1  squash IF/ID contents to a bubble next edge.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_target  in  64  new PC when redirect_valid=1.
- if_id_pc  out  64  PC of instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- halted  out  1  fetch has stopped (FSM in HALT).
- fault  out  1  sticky flag: halt was caused by a misaligned address or an out-of-range address.

Behaviour:
- Reset (async, any time including mid-operation):
  - PC=RESET_PC; if_id_valid=0; if_id_instr=NOP_INSTR (32'hD503201F); if_id_pc=0.
  - FSM=RUN; halted=0; fault=0.
- FSM states: RUN, HALT. HALT is left only by reset.
- Legal address check on PC: PC[1:0]==0 and PC+3 < MEM_SIZE. Use 64-bit compare; no wrap.
- RUN, per posedge, in priority order:
  1. redirect_valid=1: PC<=redirect_target; IF/ID<=bubble (valid=0, instr=NOP). Redirect overrides stall and flush.
  2. flush=1 and stall=0: PC<=PC+4; IF/ID<=bubble.
  3. stall=1: PC and IF/ID unchanged. When stall and flush are both high, flush is ignored.
  4. Otherwise: IF/ID<={PC, instr_in, valid=1}; PC<=PC+4.
- Illegal fetch: if PC is illegal while in RUN and no redirect is pending that cycle, then next edge:
  - FSM<=HALT; fault<=1; IF/ID<=bubble; PC holds.
  - A PC that is illegal only because of an incoming redirect_target is checked the following cycle.
- Sequential falloff: PC+4 reaching MEM_SIZE is an illegal fetch and is handled as above, so running off the end of the program halts with fault=1.
- HALT:
  - PC frozen; if_id_valid held 0; stall, flush and redirect ignored.
  - halted=1 combinationally from state.
- Latency: instruction at address A appears on if_id_instr one cycle after instr_addr=A; first valid IF/ID occurs on the first edge after reset deasserts.
- PC arithmetic is 64-bit unsigned, carry discarded.

Decomposition:
- fetch_pkg holds:
  - NOP_INSTR constant.
  - Fetch FSM enum: fetch_state_t {RUN, HALT}.
  - IF/ID struct if_id_t {pc[63:0], instr[31:0], valid}, shared with decode stage.
- One sub-module, fetch_pc_reg: PC register with next-PC mux (redirect / +4 / hold) and the legality check output.
- IF/ID register and FSM live in fetch_stage.

Test Plan:
- Reset, free-run 4 cycles, ROM holds words W0..W3 at 0,4,8,12 -> if_id_pc 0,4,8,12 with if_id_instr W0..W3, valid=1 from first edge; instr_addr 0,4,8,12,16.
- Stall high 2 cycles while PC=8 -> instr_addr stays 8, IF/ID holds {4,W1} both cycles; release -> {8,W2}.
- redirect_valid=1, target=0x40 asserted together with stall=1 -> next edge PC=0x40, if_id_valid=0; following edge IF/ID={0x40, mem[16]}.
- flush=1 at PC=12 -> IF/ID bubble (instr=NOP, valid=0), PC advances to 16.
- redirect_target=0x42 -> one cycle later halted=1, fault=1, PC frozen at 0x42, if_id_valid=0. Further redirect to 0 is ignored; reset then restores PC=0, halted=0, fault=0.
- Run sequentially to PC=1020, then next edge -> PC=1024 illegal -> halted=1, fault=1. Assert reset mid-run at PC=0x20 -> all outputs immediately at reset values.
